mealy_stream_scheduler: RTL and testbench
=========================================

# mealy_stream_scheduler

Shares one bit-serial Mealy engine among `N_REQ` requesters. Each requester offers a `WIDTH`-bit word. A round-robin arbiter grants one word at a time and shifts it LSB-first through the engine. The `WIDTH` engine output bits and the final engine state are returned on a single result port with the requester id. The block sits between the parallel word producers and the serial FSM datapath, and owns its sequencing.

## Interface
- `N_REQ`, default 4: number of requesters (2..8).
- `WIDTH`, default 8: bits per word (2..32).
- `clk`, in, 1: clock, rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, `N_REQ`: requester i has a word pending. Must be held until `req_ready[i]`.
- `req_data`, in, `N_REQ*WIDTH`: word i is at bits `[i*WIDTH +: WIDTH]`.
- `req_ready`, out, `N_REQ`: one-hot accept strobe, combinational.
- `res_valid`, out, 1: result available.
- `res_data`, out, `WIDTH`: engine output bits; bit k is the output for input bit k.
- `res_state`, out, 2: engine state after the last bit.
- `res_id`, out, `clog2(N_REQ)`: index of the requester whose word produced the result.
- `res_ready`, in, 1: consumer accepts the result.
- `busy`, out, 1: high whenever the controller is not in IDLE.

## Operation
- **Engine transition table.** Each entry is state/x → y, next state.
  - S0: x=1 → y=1, S0; x=0 → y=0, S1.
  - S1: x=1 → y=0, S3; x=0 → y=1, S2.
  - S2: x=1 → y=0, S1; x=0 → y=1, S0.
  - S3: x=1 → y=1, S2; x=0 → y=0, S3.
  - All 4 states are reachable and decoded; no latches. Encoding: S0=00, S1=01, S2=10, S3=11.
- **Controller FSM:** IDLE → SHIFT → DONE → IDLE.
- **IDLE:**
  - Grant g is the first i with `req_valid[i]=1`, searching upward from `rr_ptr` and wrapping.
  - `req_ready[g]=1` in the same cycle. On that edge the block latches the data and g, sets the engine to S0 and bit count to 0, and moves to SHIFT.
  - No valid requests: stay in IDLE; `req_ready` is all zero.
- **SHIFT:**
  - Each cycle, x = `data[cnt]`, the engine's y is written into `res_data[cnt]`, the engine advances, and cnt increments.
  - At the edge where cnt = `WIDTH-1`, move to DONE.
- **DONE:**
  - `res_valid=1`. `res_data`, `res_state` and `res_id` stay stable until `res_ready=1`.
  - On a `res_ready` edge: go to IDLE and set `rr_ptr` = (g+1) mod `N_REQ`.
- `req_ready` is zero outside IDLE. Requests arriving during SHIFT or DONE wait.
- The engine state always restarts at S0 per word; no state carries between words.
- **Reset values:** controller IDLE, `rr_ptr`=0, engine S0, cnt=0. Outputs: `res_valid`=0, `res_data`=0, `res_state`=0, `res_id`=0, `busy`=0, `req_ready`=0.
- **Reset mid-operation:** the in-flight word and any unconsumed result are discarded. The requester is not re-served.

## Timing
- Accept edge E0 is in IDLE. SHIFT occupies the `WIDTH` cycles following E0. `res_valid` rises after edge E`WIDTH`, i.e. `WIDTH` edges after acceptance.
- Peak throughput is one word per `WIDTH+2` cycles: IDLE, `WIDTH` SHIFT cycles, one DONE cycle with `res_ready` high.
- The `res_ready` → IDLE edge and the next grant are never in the same cycle. The next grant needs one IDLE cycle.
- `req_ready` is valid combinationally from `req_valid` and state. Consumers must not have combinational paths from `req_ready` to `req_valid`.
- A `res_ready` high while `res_valid` is low is ignored.

## Structure
- **Shared package** `mealy_pkg`:
  - State encodings S0..S3.
  - Controller state enum IDLE/SHIFT/DONE.
  - A next-state/output function implementing the engine table, shared with the bench reference model.
- **Sub-module** `mealy_core`: registered 2-bit state; inputs x, load_s0, en; combinational y. It is instantiated once.
- **Controller:** round-robin grant logic, bit counter, and result register in the top level.

## Test plan
- **All zeros:** `N_REQ`=4, `WIDTH`=8, requester 0 sends 8'h00 → `res_data`=8'hB6, `res_state`=2'b10, `res_id`=0, `res_valid` 8 edges after acceptance.
- **All ones:** requester 2 sends 8'hFF → `res_data`=8'hFF, `res_state`=2'b00, `res_id`=2.
- **Round robin:** all four requesters valid continuously from reset → `res_id` sequence 0,1,2,3,0, with `res_ready` tied high.
- **Backpressure:** hold `res_ready` low for 5 cycles in DONE → `res_valid`, `res_data` and `res_id` stable. `req_ready` stays 0 and `busy`=1 throughout.
- **Reset mid-shift:** assert `rst` at SHIFT cycle 3 → all outputs return to reset values at once. After release with requester 1 valid, it is granted, since `rr_ptr`=0 and requester 0 is idle.
- **Reference model:** 200 random words from random requesters with random `res_ready` stalls → every result matches the `mealy_pkg` reference model, and no requester waits more than `N_REQ-1` other grants.

Source files
------------

// File: rtl/mealy_pkg.sv
// Shared definitions for the Mealy stream scheduler.
//   - mealy_state_e : 2-bit engine state encoding (S0..S3)
//   - ctl_state_e   : controller state (idle / shift / done)
//   - mealy_step()  : engine transition and output function, one input bit per call
package mealy_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,
        S1 = 2'b01,
        S2 = 2'b10,
        S3 = 2'b11
    } mealy_state_e;

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } ctl_state_e;

    typedef struct packed {
        logic         y;
        mealy_state_e next;
    } mealy_step_t;

    // One engine step: output y for input x in state s, plus the successor state.
    function automatic mealy_step_t mealy_step(input mealy_state_e s, input logic x);
        mealy_step_t r;
        r.y    = 1'b0;
        r.next = S0;
        unique case (s)
            S0: begin
                r.y    = x;
                r.next = x ? S0 : S1;
            end
            S1: begin
                r.y    = ~x;
                r.next = x ? S3 : S2;
            end
            S2: begin
                r.y    = ~x;
                r.next = x ? S1 : S0;
            end
            S3: begin
                r.y    = x;
                r.next = x ? S2 : S3;
            end
            default: begin
                r.y    = 1'b0;
                r.next = S0;
            end
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mealy_core.sv
// Bit-serial Mealy engine with a registered 2-bit state.
//   clk, rst : clock, asynchronous active-high reset (state -> S0)
//   x        : serial input bit
//   load_s0  : restart the engine at S0 on the next edge (wins over en)
//   en       : advance the engine by one step on the next edge
//   y        : combinational output for the current state and x
//   state    : current engine state
module mealy_core
    import mealy_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         x,
    input  logic         load_s0,
    input  logic         en,
    output logic         y,
    output mealy_state_e state
);

    mealy_state_e state_q;
    mealy_state_e state_d;
    mealy_step_t  step;

    always_comb begin
        step    = mealy_step(state_q, x);
        y       = step.y;
        state_d = state_q;
        if (load_s0) begin
            state_d = S0;
        end else if (en) begin
            state_d = step.next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S0;
        end else begin
            state_q <= state_d;
        end
    end

    assign state = state_q;

endmodule

// File: rtl/mealy_stream_scheduler.sv
// Round-robin scheduler that feeds N_REQ parallel words, LSB first, through one shared
// bit-serial Mealy engine and returns the serial outputs as one result word.
//   clk, rst   : clock, asynchronous active-high reset
//   req_valid  : per-requester word pending (held until accepted)
//   req_data   : requester i word at [i*WIDTH +: WIDTH]
//   req_ready  : one-hot accept strobe, combinational, only in idle
//   res_valid  : result held in the done state
//   res_data   : engine output bits, bit k belongs to input bit k
//   res_state  : engine state after the last bit
//   res_id     : requester that produced the result
//   res_ready  : consumer accepts the result
//   busy       : controller not idle
module mealy_stream_scheduler
    import mealy_pkg::*;
#(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req_valid,
    input  logic [N_REQ*WIDTH-1:0]   req_data,
    output logic [N_REQ-1:0]         req_ready,
    output logic                     res_valid,
    output logic [WIDTH-1:0]         res_data,
    output logic [1:0]               res_state,
    output logic [$clog2(N_REQ)-1:0] res_id,
    input  logic                     res_ready,
    output logic                     busy
);

    localparam int unsigned IdW  = $clog2(N_REQ);
    localparam int unsigned CntW = $clog2(WIDTH);

    ctl_state_e         state_q, state_d;
    logic [IdW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [IdW-1:0]     id_q, id_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic [CntW-1:0]    cnt_q, cnt_d;

    logic               gnt_found;
    logic [IdW-1:0]     gnt_idx;
    logic [IdW-1:0]     cand;
    logic [WIDTH-1:0]   gnt_data;

    logic               eng_x;
    logic               eng_load;
    logic               eng_en;
    logic               eng_y;
    mealy_state_e       eng_state;

    // First valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            cand = IdW'((32'(rr_ptr_q) + k) % N_REQ);
            if (!gnt_found && req_valid[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    // Word mux for the granted requester, built with constant slices.
    always_comb begin
        gnt_data = '0;
        for (int unsigned i = 0; i < N_REQ; i++) begin
            if (gnt_idx == IdW'(i)) begin
                gnt_data = req_data[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        id_d      = id_q;
        data_d    = data_q;
        out_d     = out_q;
        cnt_d     = cnt_q;
        req_ready = '0;
        eng_x     = data_q[cnt_q];
        eng_load  = 1'b0;
        eng_en    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (gnt_found) begin
                    for (int unsigned i = 0; i < N_REQ; i++) begin
                        if (gnt_idx == IdW'(i)) begin
                            req_ready[i] = 1'b1;
                        end
                    end
                    data_d   = gnt_data;
                    id_d     = gnt_idx;
                    cnt_d    = '0;
                    eng_load = 1'b1;
                    state_d  = StShift;
                end
            end
            StShift: begin
                eng_en       = 1'b1;
                out_d[cnt_q] = eng_y;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    cnt_d   = '0;
                    state_d = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                if (res_ready) begin
                    rr_ptr_d = IdW'((32'(id_q) + 1) % N_REQ);
                    state_d  = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            rr_ptr_q <= '0;
            id_q     <= '0;
            data_q   <= '0;
            out_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            id_q     <= id_d;
            data_q   <= data_d;
            out_q    <= out_d;
            cnt_q    <= cnt_d;
        end
    end

    mealy_core u_core (
        .clk     (clk),
        .rst     (rst),
        .x       (eng_x),
        .load_s0 (eng_load),
        .en      (eng_en),
        .y       (eng_y),
        .state   (eng_state)
    );

    assign res_valid = (state_q == StDone);
    assign busy      = (state_q != StIdle);
    assign res_data  = out_q;
    assign res_state = eng_state;
    assign res_id    = id_q;

endmodule

// File: tb/tb_mealy_stream_scheduler.sv
// Scoreboard bench for mealy_stream_scheduler (N_REQ=4, WIDTH=8).
module tb_mealy_stream_scheduler;
    import mealy_pkg::*;

    localparam int N  = 4;
    localparam int W  = 8;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req_valid = '0;
    logic [N*W-1:0]    req_data  = '0;
    logic [N-1:0]      req_ready;
    logic              res_valid;
    logic [W-1:0]      res_data;
    logic [1:0]        res_state;
    logic [IW-1:0]     res_id;
    logic              res_ready = 1'b0;
    logic              busy;

    mealy_stream_scheduler #(.N_REQ(N), .WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .res_valid (res_valid),
        .res_data  (res_data),
        .res_state (res_state),
        .res_id    (res_id),
        .res_ready (res_ready),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [W-1:0]  data;
        logic [1:0]    st;
        logic [IW-1:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad = 0;
    int   results_seen = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] d, input int id);
        exp_t         m;
        mealy_state_e s;
        mealy_step_t  r;
        s = S0;
        m.data = '0;
        for (int k = 0; k < W; k++) begin
            r = mealy_step(s, d[k]);
            m.data[k] = r.y;
            s = r.next;
        end
        m.st = s;
        m.id = IW'(id);
        return m;
    endfunction

    // Cycle-level predictor: expected handshakes, timing, and scoreboard entries.
    ctl_state_e m_st = StIdle;
    int m_ptr = 0;
    int m_id = 0;
    int m_cnt = 0;
    int wait_cnt[N];

    always @(negedge clk) begin
        if (rst) begin
            m_st = StIdle;
            m_ptr = 0;
            m_cnt = 0;
            exp_q.delete();
            for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        end else begin
            chk("busy", 64'(busy), 64'(m_st != StIdle));
            chk("res_valid timing", 64'(res_valid), 64'(m_st == StDone));
            case (m_st)
                StIdle: begin
                    bit           found;
                    int           g;
                    logic [W-1:0] wd;
                    found = 1'b0;
                    g = 0;
                    for (int k = 0; k < N; k++) begin
                        int c;
                        c = (m_ptr + k) % N;
                        if (!found && req_valid[c]) begin
                            found = 1'b1;
                            g = c;
                        end
                    end
                    if (found) begin
                        chk("req_ready grant", 64'(req_ready), 64'(1) << g);
                        wd = W'(req_data >> (g * W));
                        exp_q.push_back(model(wd, g));
                        for (int i = 0; i < N; i++) begin
                            if (i != g && req_valid[i]) begin
                                wait_cnt[i]++;
                                total++;
                                if (wait_cnt[i] > N - 1) begin
                                    bad++;
                                    $display("FAIL starvation: requester %0d waited %0d grants, limit %0d",
                                             i, wait_cnt[i], N - 1);
                                end
                            end
                        end
                        wait_cnt[g] = 0;
                        m_id = g;
                        m_cnt = 0;
                        m_st = StShift;
                    end else begin
                        chk("req_ready idle", 64'(req_ready), 64'd0);
                    end
                end
                StShift: begin
                    chk("req_ready shift", 64'(req_ready), 64'd0);
                    m_cnt++;
                    if (m_cnt == W) m_st = StDone;
                end
                default: begin
                    chk("req_ready done", 64'(req_ready), 64'd0);
                    if (res_ready) begin
                        m_ptr = (m_id + 1) % N;
                        m_st = StIdle;
                    end
                end
            endcase
        end
    end

    // Monitor: pops and compares on every result handshake, checks hold stability.
    bit            held = 1'b0;
    logic [W-1:0]  held_data;
    logic [1:0]    held_st;
    logic [IW-1:0] held_id;

    always @(negedge clk) begin
        if (rst) begin
            held = 1'b0;
        end else if (res_valid) begin
            if (held) begin
                chk("hold res_data", 64'(res_data), 64'(held_data));
                chk("hold res_state", 64'(res_state), 64'(held_st));
                chk("hold res_id", 64'(res_id), 64'(held_id));
            end
            if (res_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected result", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("sb res_data", 64'(res_data), 64'(e.data));
                    chk("sb res_state", 64'(res_state), 64'(e.st));
                    chk("sb res_id", 64'(res_id), 64'(e.id));
                end
                results_seen++;
                held = 1'b0;
            end else begin
                held = 1'b1;
                held_data = res_data;
                held_st = res_state;
                held_id = res_id;
            end
        end else begin
            held = 1'b0;
        end
    end

    task automatic apply_reset();
        req_valid = '0;
        res_ready = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    task automatic issue(input int id, input logic [W-1:0] d);
        req_data[id*W +: W] = d;
        req_valid[id] = 1'b1;
    endtask

    task automatic accept(input int id);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (req_ready[id]) begin
                ok = 1'b1;
                break;
            end
        end
        chk("accept seen", 64'(ok), 64'd1);
        @(posedge clk);
        #1 req_valid[id] = 1'b0;
    endtask

    task automatic result(input logic [W-1:0] ed, input logic [1:0] es, input int eid,
                          input string nm);
        int e;
        bit got;
        e = 0;
        got = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            if (res_valid) begin
                got = 1'b1;
                break;
            end
            @(posedge clk);
            e++;
        end
        chk({nm, " res_valid seen"}, 64'(got), 64'd1);
        if (got) begin
            chk({nm, " latency"}, 64'(e), 64'(W));
            chk({nm, " res_data"}, 64'(res_data), 64'(ed));
            chk({nm, " res_state"}, 64'(res_state), 64'(es));
            chk({nm, " res_id"}, 64'(res_id), 64'(eid));
        end
    endtask

    task automatic release_res();
        @(posedge clk);
        #1 res_ready = 1'b1;
        @(posedge clk);
        #1 res_ready = 1'b0;
    endtask

    task automatic chk_reset_outputs(input string nm);
        chk({nm, " res_valid"}, 64'(res_valid), 64'd0);
        chk({nm, " res_data"}, 64'(res_data), 64'd0);
        chk({nm, " res_state"}, 64'(res_state), 64'd0);
        chk({nm, " res_id"}, 64'(res_id), 64'd0);
        chk({nm, " busy"}, 64'(busy), 64'd0);
        chk({nm, " req_ready"}, 64'(req_ready), 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: actual=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    int rr_exp[5] = '{0, 1, 2, 3, 0};

    initial begin
        int n;
        int start;
        int issued;
        int cyc;
        bit acc[N];

        #1 apply_reset();
        chk_reset_outputs("reset");

        // All zeros from requester 0.
        issue(0, 8'h00);
        accept(0);
        result(8'hB6, 2'b10, 0, "zeros");
        release_res();

        // All ones from requester 2.
        issue(2, 8'hFF);
        accept(2);
        result(8'hFF, 2'b00, 2, "ones");
        release_res();

        // Backpressure on requester 3 while requester 0 waits.
        issue(3, 8'h0F);
        accept(3);
        result(8'h6F, 2'b01, 3, "bp");
        #1 issue(0, 8'h55);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("bp res_valid", 64'(res_valid), 64'd1);
            chk("bp res_data", 64'(res_data), 64'h6F);
            chk("bp res_id", 64'(res_id), 64'd3);
            chk("bp req_ready", 64'(req_ready), 64'd0);
            chk("bp busy", 64'(busy), 64'd1);
        end
        release_res();
        accept(0);
        result(8'h71, 2'b01, 0, "after bp");
        release_res();

        // Round robin with every requester valid and res_ready tied high.
        apply_reset();
        issue(0, 8'h00);
        issue(1, 8'hFF);
        issue(2, 8'h0F);
        issue(3, 8'h55);
        res_ready = 1'b1;
        n = 0;
        for (int t = 0; t < 200 && n < 5; t++) begin
            @(negedge clk);
            if (res_valid) begin
                chk("rr res_id", 64'(res_id), 64'(rr_exp[n]));
                n++;
            end
        end
        chk("rr count", 64'(n), 64'd5);
        @(posedge clk);
        #1 req_valid = '0;
        res_ready = 1'b0;

        // Reset in the middle of a shift.
        apply_reset();
        issue(2, 8'hA5);
        accept(2);
        repeat (3) @(posedge clk);
        #1 chk("mid busy", 64'(busy), 64'd1);
        rst = 1'b1;
        #1 chk_reset_outputs("mid reset");
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        issue(1, 8'hFF);
        issue(3, 8'h00);
        accept(1);
        result(8'hFF, 2'b00, 1, "post rst r1");
        release_res();
        accept(3);
        result(8'hB6, 2'b10, 3, "post rst r3");
        release_res();

        // Random words, random requesters, random result stalls.
        start = results_seen;
        issued = 0;
        cyc = 0;
        for (int i = 0; i < N; i++) acc[i] = 1'b0;
        while ((results_seen - start) < 200 && cyc < 30000) begin
            @(negedge clk);
            for (int i = 0; i < N; i++) begin
                if (req_valid[i] && req_ready[i]) acc[i] = 1'b1;
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i]) begin
                    req_valid[i] = 1'b0;
                    acc[i] = 1'b0;
                end
                if (!req_valid[i] && issued < 200 && $urandom_range(0, 2) == 0) begin
                    req_data[i*W +: W] = W'($urandom);
                    req_valid[i] = 1'b1;
                    issued++;
                end
            end
            res_ready = ($urandom_range(0, 3) != 0);
            cyc++;
        end
        chk("random results", 64'(results_seen - start), 64'd200);
        res_ready = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
